// File: rtl/flash_sample_reader.sv
// Streams 16-bit audio samples out of 32-bit flash words, two samples per word.
// Optional read watchdog: define READ_TIMEOUT_EN to abort and retry stalled reads.
module flash_sample_reader #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        sample_tick,
    input  logic        address_direction,
    input  logic [22:0] reading_address,
    output logic        changing_address,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    input  logic        flash_mem_waitrequest,
    input  logic        flash_mem_readdatavalid,
    input  logic [31:0] flash_mem_readdata,
    output logic [15:0] audio_sample,
    output logic        sample_valid,
    output logic        underrun,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        FIRST,
        SECOND,
        ADVANCE
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] word;
    logic        dir;
    logic        accept;
    logic        data_arrived;
    logic        wd_abort;
    logic [15:0] first_half;
    logic [15:0] second_half;

    // read is raised one cycle into REQ, so a handshake only counts once it is asserted
    assign accept       = (state == REQ) && flash_mem_read && !flash_mem_waitrequest;
    assign data_arrived = (state == WAIT_DATA) && flash_mem_readdatavalid;
    assign first_half   = dir ? word[15:0]  : word[31:16];
    assign second_half  = dir ? word[31:16] : word[15:0];

`ifdef READ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_count;
    logic            wd_fire;

    assign wd_fire  = ((state == REQ) || (state == WAIT_DATA)) &&
                      (wd_count == WD_W'(TIMEOUT_CYCLES - 1));
    // a handshake completing on the limit cycle wins over the abort
    assign wd_abort = wd_fire && !accept && !data_arrived;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_count <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= wd_abort;
            if (wd_abort || (next_state != state)) begin
                wd_count <= '0;
            end else if ((state == REQ) || (state == WAIT_DATA)) begin
                wd_count <= wd_count + 1'b1;
            end else begin
                wd_count <= '0;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wd_abort           = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (enable)                  next_state = REQ;
            REQ:       if (accept)                  next_state = WAIT_DATA;
            WAIT_DATA: if (flash_mem_readdatavalid) next_state = FIRST;
            FIRST:     if (sample_tick)             next_state = SECOND;
            SECOND:    if (sample_tick)             next_state = ADVANCE;
            ADVANCE:   next_state = enable ? REQ : IDLE;
            default:   next_state = IDLE;
        endcase
        if (wd_abort) begin
            next_state = REQ;
        end
    end

    // Ticks only count while a word is loaded; anywhere else they are dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flash_mem_read    <= 1'b0;
            flash_mem_address <= '0;
            word              <= '0;
            dir               <= 1'b0;
            audio_sample      <= '0;
            sample_valid      <= 1'b0;
            changing_address  <= 1'b0;
            underrun          <= 1'b0;
        end else begin
            sample_valid     <= 1'b0;
            changing_address <= 1'b0;
            underrun         <= sample_tick &&
                                ((state == REQ) || (state == WAIT_DATA) || (state == ADVANCE));

            flash_mem_read <= (state == REQ) && !accept && !wd_abort;
            if ((state == REQ) && !flash_mem_read) begin
                flash_mem_address <= reading_address;
            end

            if (data_arrived) begin
                word <= flash_mem_readdata;
                dir  <= address_direction;
            end

            if ((state == FIRST) && sample_tick) begin
                audio_sample <= first_half;
                sample_valid <= 1'b1;
            end

            if ((state == SECOND) && sample_tick) begin
                audio_sample     <= second_half;
                sample_valid     <= 1'b1;
                changing_address <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Scoreboard bench for flash_sample_reader: directed words, expected samples queued ahead.
// Build with READ_TIMEOUT_EN defined to exercise the watchdog path.
module tb_flash_sample_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        sample_tick;
    logic        address_direction;
    logic [22:0] reading_address;
    logic        changing_address;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        flash_mem_waitrequest;
    logic        flash_mem_readdatavalid;
    logic [31:0] flash_mem_readdata;
    logic [15:0] audio_sample;
    logic        sample_valid;
    logic        underrun;
    logic        timeout;

    typedef struct {
        logic [15:0] sample;
        logic        chg;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    flash_sample_reader #(.TIMEOUT_CYCLES(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .enable                  (enable),
        .sample_tick             (sample_tick),
        .address_direction       (address_direction),
        .reading_address         (reading_address),
        .changing_address        (changing_address),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .flash_mem_readdata      (flash_mem_readdata),
        .audio_sample            (audio_sample),
        .sample_valid            (sample_valid),
        .underrun                (underrun),
        .timeout                 (timeout)
    );

    // Stand-in address generator: steps on each changing_address pulse.
    always @(posedge clk) begin
        if (!reset_n) begin
            reading_address <= 23'h000100;
        end else if (changing_address) begin
            reading_address <= address_direction ? reading_address + 23'd1
                                                 : reading_address - 23'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic tick, input logic rdv,
                                 input logic [31:0] data, input int cycles);
        sample_tick             = tick;
        flash_mem_readdatavalid = rdv;
        flash_mem_readdata      = data;
        repeat (cycles) @(negedge clk);
        sample_tick             = 1'b0;
        flash_mem_readdatavalid = 1'b0;
    endtask

    task automatic pushExpect(input logic [15:0] sample, input logic chg);
        exp_t e;
        e.sample = sample;
        e.chg    = chg;
        exp_q.push_back(e);
    endtask

    task automatic waitRead(input string name);
        int n = 0;
        while (!flash_mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, flash_mem_read}, 32'd1);
    endtask

    task automatic fetchWord(input logic [31:0] data, input string name);
        waitRead({name, "_read"});
        @(negedge clk);
        checkOutput({name, "_read_drop"}, {31'd0, flash_mem_read}, 32'd0);
        applyStimulus(1'b0, 1'b1, data, 1);
    endtask

    // Monitor: every sample_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && changing_address && !sample_valid) begin
            checkOutput("chg_without_valid", 32'd1, 32'd0);
        end
        if (reset_n && sample_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", {16'd0, audio_sample}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sample", {16'd0, audio_sample}, {16'd0, e.sample});
                checkOutput("sample_chg", {31'd0, changing_address}, {31'd0, e.chg});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        logic [22:0] saved_addr;
        int          n;

        reset_n                 = 1'b0;
        enable                  = 1'b1;
        sample_tick             = 1'b0;
        address_direction       = 1'b1;
        flash_mem_waitrequest   = 1'b1;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("rst_read",     {31'd0, flash_mem_read},   32'd0);
        checkOutput("rst_addr",     {9'd0, flash_mem_address}, 32'd0);
        checkOutput("rst_audio",    {16'd0, audio_sample},     32'd0);
        checkOutput("rst_valid",    {31'd0, sample_valid},     32'd0);
        checkOutput("rst_chg",      {31'd0, changing_address}, 32'd0);
        checkOutput("rst_underrun", {31'd0, underrun},         32'd0);
        checkOutput("rst_timeout",  {31'd0, timeout},          32'd0);

        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_read_c1", {31'd0, flash_mem_read}, 32'd0);

        // waitrequest high for three accepting edges keeps read/address stable four cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_read", {31'd0, flash_mem_read},   32'd1);
            checkOutput("stall_addr", {9'd0, flash_mem_address}, 32'h100);
        end
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        checkOutput("accept_read_drop", {31'd0, flash_mem_read}, 32'd0);

        applyStimulus(1'b1, 1'b0, 32'd0, 1);
        checkOutput("wait_underrun", {31'd0, underrun},     32'd1);
        checkOutput("wait_audio",    {16'd0, audio_sample}, 32'd0);
        checkOutput("wait_valid",    {31'd0, sample_valid}, 32'd0);

        // tick arriving with the data must not be consumed by FIRST
        applyStimulus(1'b1, 1'b1, 32'hBEEF1234, 1);
        checkOutput("entry_underrun", {31'd0, underrun},     32'd1);
        checkOutput("entry_valid",    {31'd0, sample_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 2);

        pushExpect(16'h1234, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1);
        pushExpect(16'hBEEF, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1);
        waitRead("fwd_next_read");
        checkOutput("fwd_next_addr", {9'd0, flash_mem_address}, 32'h101);

        address_direction = 1'b0;
        @(negedge clk);
        checkOutput("bwd_read_drop", {31'd0, flash_mem_read}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hBEEF1234, 1);
        applyStimulus(1'b0, 1'b1, 32'hDEAD0000, 1);
        pushExpect(16'hBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1);
        address_direction = 1'b1;
        enable            = 1'b0;
        pushExpect(16'h1234, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1);
        repeat (3) @(negedge clk);
        checkOutput("halt_read", {31'd0, flash_mem_read}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1);
        checkOutput("idle_tick_underrun", {31'd0, underrun},     32'd0);
        checkOutput("idle_tick_audio",    {16'd0, audio_sample}, 32'h1234);

        enable = 1'b1;
        waitRead("rst_mid_read");
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_read",  {31'd0, flash_mem_read},   32'd0);
        checkOutput("mid_rst_addr",  {9'd0, flash_mem_address}, 32'd0);
        checkOutput("mid_rst_audio", {16'd0, audio_sample},     32'd0);
        reset_n = 1'b1;
        enable  = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h55556666, 1);
        repeat (2) @(negedge clk);
        checkOutput("post_rst_valid", {31'd0, sample_valid},   32'd0);
        checkOutput("post_rst_read",  {31'd0, flash_mem_read}, 32'd0);
        checkOutput("post_rst_audio", {16'd0, audio_sample},   32'd0);

        enable = 1'b1;
        fetchWord(32'hA5A50F0F, "recover");
        checkOutput("recover_addr", {9'd0, flash_mem_address}, 32'h100);
        pushExpect(16'h0F0F, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1);
        pushExpect(16'hA5A5, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1);

`ifdef READ_TIMEOUT_EN
        waitRead("to_read");
        saved_addr = flash_mem_address;
        n = 0;
        while (!timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_latency", n, 32'd9);
        @(negedge clk);
        checkOutput("to_pulse",   {31'd0, timeout},          32'd0);
        checkOutput("to_reread",  {31'd0, flash_mem_read},   32'd1);
        checkOutput("to_addr",    {9'd0, flash_mem_address}, {9'd0, saved_addr});
`else
        waitRead("no_to_read");
        saved_addr = flash_mem_address;
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (timeout) n++;
        end
        checkOutput("no_to_pulses", n, 32'd0);
        checkOutput("no_to_read",   {31'd0, flash_mem_read},   32'd0);
        checkOutput("no_to_addr",   {9'd0, flash_mem_address}, {9'd0, saved_addr});
`endif

        repeat (2) @(negedge clk);
        checkOutput("leftover_expect", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
